sha256_stream_ctrl: RTL

Message front-end and initiator for the SHA-256 core. Accepts a byte message as a stream of 32-bit big-endian words, assembles 512-bit blocks, applies SHA-256 padding (0x80, zeros, 64-bit bit length), and drives the core's `init`/`next`/`block` inputs. It waits on the core's `ready`/`digest_valid` and returns the 256-bit digest on a valid/ready output port. It sits between the bus/DMA wrapper and the core; one message is processed at a time.

---
 rtl/sha256_stream_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sha256_stream_ctrl.sv
// rtl/sha256_stream_ctrl.sv - SHA-256 message front-end: block assembly, padding and core sequencing
module sha256_stream_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_nbytes,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_digest_valid,
    input  logic [255:0] core_digest,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [255:0] m_digest
);
    typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT_BUSY, WAIT_DONE, OUT} state_t;

    state_t           state, state_d;
    logic [0:15][31:0] blk;
    logic [3:0]       wp, wp_d;
    logic [63:0]      len, len_d;
    logic             first, first_d;
    logic             pad80_pending, pad80_d;
    logic             final_blk, final_d;
    logic             pad_more, pad_more_d;
    logic             spill, spill_d;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             init_d, next_d, digest_ld;
    logic [31:0]      last_word;

    // Short last beat: keep the valid bytes, put the 0x80 marker right after them.
    always_comb begin
        case (s_nbytes)
            3'd1:    last_word = {s_data[31:24], 24'h800000};
            3'd2:    last_word = {s_data[31:16], 16'h8000};
            3'd3:    last_word = {s_data[31:8], 8'h80};
            default: last_word = s_data;
        endcase
    end

    always_comb begin
        state_d    = state;
        wp_d       = wp;
        len_d      = len;
        first_d    = first;
        pad80_d    = pad80_pending;
        final_d    = final_blk;
        pad_more_d = pad_more;
        spill_d    = spill;
        wr_en      = 1'b0;
        wr_data    = 32'h0;
        init_d     = 1'b0;
        next_d     = 1'b0;
        digest_ld  = 1'b0;
        case (state)
            FILL: begin
                if (s_valid) begin
                    if (!s_last) begin
                        wr_en   = 1'b1;
                        wr_data = s_data;
                        wp_d    = wp + 4'd1;
                        len_d   = len + 64'd32;
                        if (wp == 4'd15) begin
                            state_d = ISSUE;
                            final_d = 1'b0;
                        end
                    end else begin
                        state_d = PAD;
                        case (s_nbytes)
                            3'd0: pad80_d = 1'b1;
                            3'd1, 3'd2, 3'd3: begin
                                wr_en   = 1'b1;
                                wr_data = last_word;
                                wp_d    = wp + 4'd1;
                                len_d   = len + {58'd0, s_nbytes, 3'b000};
                                if (wp == 4'd14)
                                    spill_d = 1'b1;
                            end
                            default: begin
                                wr_en   = 1'b1;
                                wr_data = s_data;
                                wp_d    = wp + 4'd1;
                                len_d   = len + 64'd32;
                                pad80_d = 1'b1;
                            end
                        endcase
                        // A last beat filling word 15 completes this block; padding continues in the next one.
                        if (s_nbytes != 3'd0 && wp == 4'd15) begin
                            state_d    = ISSUE;
                            final_d    = 1'b0;
                            pad_more_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                wr_en = 1'b1;
                wp_d  = wp + 4'd1;
                if (pad80_pending) begin
                    wr_data = 32'h8000_0000;
                    pad80_d = 1'b0;
                    if (wp == 4'd15) begin
                        state_d    = ISSUE;
                        final_d    = 1'b0;
                        pad_more_d = 1'b1;
                    end else if (wp == 4'd14) begin
                        spill_d = 1'b1;
                    end
                end else if (spill) begin
                    wr_data = 32'h0;
                    if (wp == 4'd15) begin
                        state_d    = ISSUE;
                        final_d    = 1'b0;
                        pad_more_d = 1'b1;
                        spill_d    = 1'b0;
                    end
                end else if (wp < 4'd14) begin
                    wr_data = 32'h0;
                end else if (wp == 4'd14) begin
                    wr_data = len[63:32];
                end else begin
                    wr_data = len[31:0];
                    state_d = ISSUE;
                    final_d = 1'b1;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    init_d  = first;
                    next_d  = ~first;
                    first_d = 1'b0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!core_ready)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_ready && core_digest_valid) begin
                    if (final_blk) begin
                        digest_ld = 1'b1;
                        state_d   = OUT;
                    end else begin
                        wp_d       = 4'd0;
                        pad_more_d = 1'b0;
                        state_d    = pad_more ? PAD : FILL;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    len_d      = 64'd0;
                    wp_d       = 4'd0;
                    pad_more_d = 1'b0;
                    pad80_d    = 1'b0;
                    spill_d    = 1'b0;
                    first_d    = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FILL;
            blk           <= '0;
            wp            <= 4'd0;
            len           <= 64'd0;
            first         <= 1'b1;
            pad80_pending <= 1'b0;
            final_blk     <= 1'b0;
            pad_more      <= 1'b0;
            spill         <= 1'b0;
            core_init     <= 1'b0;
            core_next     <= 1'b0;
            m_digest      <= '0;
        end else begin
            state         <= state_d;
            wp            <= wp_d;
            len           <= len_d;
            first         <= first_d;
            pad80_pending <= pad80_d;
            final_blk     <= final_d;
            pad_more      <= pad_more_d;
            spill         <= spill_d;
            core_init     <= init_d;
            core_next     <= next_d;
            if (wr_en)
                blk[wp] <= wr_data;
            if (digest_ld)
                m_digest <= core_digest;
        end
    end

    assign s_ready    = (state == FILL);
    assign m_valid    = (state == OUT);
    assign core_block = blk;
endmodule
